// File: rtl/pio_pkg.sv
// Shared types and constants for the PIO TX output-shift-register path.
// Count widths derive from the default data width; direction encodes the shift_right input.
package pio_pkg;

  localparam int PIO_DATA_W = 32;
  localparam int PIO_N_W    = $clog2(PIO_DATA_W);
  localparam int PIO_CNT_W  = PIO_N_W + 1;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } osr_state_e;

  localparam logic SHIFT_LEFT  = 1'b0;
  localparam logic SHIFT_RIGHT = 1'b1;

endpackage

// File: rtl/tx_pull_ctrl_if.sv
// Bundle of TX FIFO handshake and execution-unit request/response signals.
// slave = the OSR controller, master = execution unit plus FIFO side.
interface tx_pull_ctrl_if #(parameter int DATA_W = 32);

  localparam int NW = $clog2(DATA_W);

  logic              fifo_pop_en;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_empty;
  logic              shift_req;
  logic [NW-1:0]     shift_cnt;
  logic              shift_right;
  logic              pull_req;
  logic              pull_block;
  logic [DATA_W-1:0] pull_nb_data;
  logic              autopull_en;
  logic [NW-1:0]     pull_thresh;
  logic [DATA_W-1:0] shift_data;
  logic              done;
  logic              stall;
  logic [NW:0]       osr_count;

  modport master (
    input  fifo_pop_en, shift_data, done, stall, osr_count,
    output fifo_data, fifo_empty, shift_req, shift_cnt, shift_right,
           pull_req, pull_block, pull_nb_data, autopull_en, pull_thresh
  );

  modport slave (
    output fifo_pop_en, shift_data, done, stall, osr_count,
    input  fifo_data, fifo_empty, shift_req, shift_cnt, shift_right,
           pull_req, pull_block, pull_nb_data, autopull_en, pull_thresh
  );

endinterface

// File: rtl/tx_pull_ctrl_osr_shifter.sv
// Combinational OSR shifter: n in 1..DATA_W, returns the bits shifted out
// (right-aligned, zero-extended) and the remaining word with zero fill.
module osr_shifter
  import pio_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CW     = $clog2(DATA_W) + 1
) (
  input  logic [DATA_W-1:0] word,
  input  logic [CW-1:0]     n,
  input  logic              dir,
  output logic [DATA_W-1:0] shift_data,
  output logic [DATA_W-1:0] next_word
);

  localparam logic [CW-1:0] FULL = CW'(DATA_W);

  // Shifting by the full width yields zero, so n == DATA_W needs no special case.
  always_comb begin
    if (dir == SHIFT_RIGHT) begin
      shift_data = word & ~({DATA_W{1'b1}} << n);
      next_word  = word >> n;
    end else begin
      shift_data = word >> (FULL - n);
      next_word  = word << n;
    end
  end

endmodule

// File: rtl/tx_pull_ctrl.sv
// OSR controller between PIO execution unit and TX FIFO: OUT shifts, PULL, autopull.
// Autopull refills are compiled in only when TX_PULL_AUTOPULL_EN is defined.
module tx_pull_ctrl
  import pio_pkg::*;
#(
  parameter int DATA_W = PIO_DATA_W
) (
  input  logic           clk,
  input  logic           rst,
  tx_pull_ctrl_if.slave  bus
);

  localparam int NW = $clog2(DATA_W);
  localparam int CW = NW + 1;
  localparam logic [CW-1:0] FULL = CW'(DATA_W);

  osr_state_e        state;
  logic [DATA_W-1:0] osr;
  logic [CW-1:0]     osr_count;
  logic [DATA_W-1:0] shift_data_q;
  logic              done_q;
  logic              ld_pull;

  logic [CW-1:0]     n_eff;
  logic [CW:0]       cnt_sum;
  logic [CW-1:0]     cnt_next;
  logic              refill;
  logic              pop_go;
  logic [DATA_W-1:0] sh_word;
  logic [DATA_W-1:0] sh_data;
  logic [DATA_W-1:0] sh_next;

  assign n_eff    = (bus.shift_cnt == '0) ? FULL : {1'b0, bus.shift_cnt};
  assign cnt_sum  = {1'b0, osr_count} + {1'b0, n_eff};
  assign cnt_next = (cnt_sum > {1'b0, FULL}) ? FULL : cnt_sum[CW-1:0];

`ifdef TX_PULL_AUTOPULL_EN
  logic [CW-1:0] thresh_eff;
  assign thresh_eff = (bus.pull_thresh == '0) ? FULL : {1'b0, bus.pull_thresh};
  assign refill     = bus.autopull_en & (osr_count >= thresh_eff);
`else
  logic unused_autopull;
  assign unused_autopull = ^{bus.autopull_en, bus.pull_thresh};
  assign refill          = 1'b0;
`endif

  // Pop only when the FIFO reports data; its underflow guard is never exercised.
  assign pop_go = (state == IDLE) & ~done_q & ~bus.fifo_empty &
                  (bus.pull_req | (bus.shift_req & refill));

  assign bus.fifo_pop_en = pop_go & ~rst;
  assign bus.shift_data  = shift_data_q;
  assign bus.done        = done_q;
  assign bus.osr_count   = osr_count;
  assign bus.stall       = (bus.shift_req | bus.pull_req) & ~done_q;

  // In LOAD the popped word arrives on fifo_data and is shifted in place.
  assign sh_word = (state == LOAD) ? bus.fifo_data : osr;

  osr_shifter #(.DATA_W(DATA_W), .CW(CW)) u_shifter (
    .word       (sh_word),
    .n          (n_eff),
    .dir        (bus.shift_right),
    .shift_data (sh_data),
    .next_word  (sh_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      osr          <= '0;
      osr_count    <= FULL;
      shift_data_q <= '0;
      done_q       <= 1'b0;
      ld_pull      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (pop_go) begin
            state   <= LOAD;
            ld_pull <= bus.pull_req;
          end else if (!done_q && bus.pull_req && bus.fifo_empty && !bus.pull_block) begin
            osr       <= bus.pull_nb_data;
            osr_count <= '0;
            done_q    <= 1'b1;
          end else if (!done_q && !bus.pull_req && bus.shift_req && !refill) begin
            shift_data_q <= sh_data;
            osr          <= sh_next;
            osr_count    <= cnt_next;
            done_q       <= 1'b1;
          end
        end
        LOAD: begin
          if (ld_pull) begin
            osr       <= bus.fifo_data;
            osr_count <= '0;
          end else begin
            shift_data_q <= sh_data;
            osr          <= sh_next;
            osr_count    <= n_eff;
          end
          state  <= IDLE;
          done_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
